// File: rtl/rtc_bus_scoreboard.sv
// Bus scoreboard for the RTC/alarm register block: shadows TIME and the alarm slots,
// checks APB-style sequencing, access timeouts and read data, and logs errors.
module rtc_bus_scoreboard #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 enable,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 ready,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 tick,
    input  logic                 fail_clr,
    output logic                 fail,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [2:0]           err_code,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [2:0]           first_code,
    output logic [ERR_CNT_W-1:0] txn_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned AIDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    localparam logic [2:0] E_PROTO   = 3'd1;
    localparam logic [2:0] E_CHANGE  = 3'd2;
    localparam logic [2:0] E_TIMEOUT = 3'd3;
    localparam logic [2:0] E_RDATA   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cap_addr, cap_addr_nxt;
    logic                cap_write, cap_write_nxt;
    logic [DATA_W-1:0]   cap_wdata, cap_wdata_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;

    logic [DATA_W-1:0]   time_q;
    logic [DATA_W-1:0]   alarm_q [NUM_ALARMS];

    logic [ADDR_W-1:0]   word_c;
    logic                time_hit_c;
    logic                alarm_hit_c;
    logic [AIDX_W-1:0]   alarm_idx_c;
    logic [DATA_W-1:0]   exp_rdata_c;
    logic                same_c;
    logic [WAIT_W-1:0]   wait_inc_c;

    logic                done_c;
    logic                err_c;
    logic [2:0]          err_code_c;
    logic [ADDR_W-1:0]   err_addr_c;

    // Register map decode on the captured address
    assign word_c      = cap_addr >> 2;
    assign time_hit_c  = (cap_addr == '0);
    assign alarm_hit_c = (cap_addr[1:0] == 2'b00) && (word_c != '0) &&
                         (word_c <= ADDR_W'(NUM_ALARMS));
    assign alarm_idx_c = AIDX_W'(word_c - ADDR_W'(1));

    always_comb begin
        exp_rdata_c = '0;
        if (time_hit_c) begin
            exp_rdata_c = time_q;
        end else if (alarm_hit_c) begin
            exp_rdata_c = alarm_q[alarm_idx_c];
        end
    end

    assign same_c = sel && enable && (addr == cap_addr) && (write == cap_write) &&
                    (wdata == cap_wdata);
    assign wait_inc_c = wait_cnt + WAIT_W'(1);

    // Phase checker: state holds the bus phase seen in the previous cycle
    always_comb begin
        state_nxt     = state;
        cap_addr_nxt  = cap_addr;
        cap_write_nxt = cap_write;
        cap_wdata_nxt = cap_wdata;
        wait_nxt      = wait_cnt;
        done_c        = 1'b0;
        err_c         = 1'b0;
        err_code_c    = '0;
        err_addr_c    = cap_addr;
        case (state)
            S_IDLE: begin
                if (sel && !enable) begin
                    state_nxt     = S_SETUP;
                    cap_addr_nxt  = addr;
                    cap_write_nxt = write;
                    cap_wdata_nxt = wdata;
                end else if (sel && enable) begin
                    err_c      = 1'b1;
                    err_code_c = E_PROTO;
                    err_addr_c = addr;
                end
            end
            S_SETUP: begin
                if (!same_c) begin
                    err_c      = 1'b1;
                    err_code_c = E_PROTO;
                    err_addr_c = addr;
                    state_nxt  = S_IDLE;
                end else if (ready) begin
                    done_c    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ACCESS;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            S_ACCESS: begin
                if (!same_c) begin
                    err_c      = 1'b1;
                    err_code_c = E_CHANGE;
                    state_nxt  = S_IDLE;
                    wait_nxt   = '0;
                end else if (ready) begin
                    done_c    = 1'b1;
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end else if (wait_inc_c == WAIT_W'(TIMEOUT)) begin
                    err_c      = 1'b1;
                    err_code_c = E_TIMEOUT;
                    state_nxt  = S_IDLE;
                    wait_nxt   = '0;
                end else begin
                    wait_nxt = wait_inc_c;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (done_c && !cap_write && (rdata != exp_rdata_c)) begin
            err_c      = 1'b1;
            err_code_c = E_RDATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_write <= cap_write_nxt;
            cap_wdata <= cap_wdata_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    // Shadow registers; a TIME write in a tick cycle wins over the increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= '0;
            end
        end else begin
            if (done_c && cap_write && time_hit_c) begin
                time_q <= cap_wdata;
            end else if (tick) begin
                time_q <= time_q + DATA_W'(1);
            end
            if (done_c && cap_write && alarm_hit_c) begin
                alarm_q[alarm_idx_c] <= {cap_wdata[DATA_W-1:1], 1'b1};
            end
        end
    end

    // Error log; a same-cycle error overrides fail_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail       <= 1'b0;
            err_count  <= '0;
            err_code   <= '0;
            err_addr   <= '0;
            first_code <= '0;
        end else if (err_c) begin
            fail     <= 1'b1;
            err_code <= err_code_c;
            err_addr <= err_addr_c;
            if (fail_clr) begin
                err_count <= ERR_CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
            if (!fail || fail_clr) begin
                first_code <= err_code_c;
            end
        end else if (fail_clr) begin
            fail       <= 1'b0;
            err_count  <= '0;
            err_code   <= '0;
            err_addr   <= '0;
            first_code <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_count <= '0;
        end else if (done_c) begin
            txn_count <= txn_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: doc/rtc_bus_scoreboard.md
Name: rtc_bus_scoreboard

Overview:
Synthesizable, parametrised bus scoreboard for the RTC/alarm register block. It watches the APB-style bus (sel/enable/write/addr/wdata/ready/rdata) and keeps a shadow model of the time register and NUM_ALARMS alarm slots. It checks protocol sequencing, access timeouts and read data against the shadow, and reports through a sticky fail flag, an error counter and first/last-error capture. It sits beside the DUT in the bench and in emulation builds, and replaces the fixed-function behavioural checker.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 32, bus data width
NUM_ALARMS, 4, number of alarm slots modelled (1..16)
TIMEOUT, 16, max cycles in access phase without ready before a timeout error
ERR_CNT_W, 16, error counter width

Ports:
clk  in  1  bus clock
reset  in  1  asynchronous active-low reset
sel  in  1  bus select
enable  in  1  bus enable (access phase)
write  in  1  1=write, 0=read
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data
ready  in  1  DUT ready
rdata  in  DATA_W  DUT read data
tick  in  1  one-cycle pulse; DUT time advances by 1
fail_clr  in  1  clears fail/err_count/err_code
fail  out  1  sticky error flag
err_count  out  ERR_CNT_W  saturating error count
err_code  out  3  code of most recent error
err_addr  out  ADDR_W  address of most recent error
first_code  out  3  code of first error since reset/clear
txn_count  out  ERR_CNT_W  completed transfers, wraps

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM IDLE, shadow time 0, alarm slots 0, wait counter 0.
- Map: 0x00 TIME; 0x04+4*i ALARMi for i<NUM_ALARMS; everything else unmapped (writes ignored, reads expect 0).
- FSM state is the bus phase of the previous cycle. The current cycle's bus is checked against it:
  - IDLE: sel&!enable -> SETUP, capture addr/write/wdata. sel&enable -> error 1, stay IDLE.
  - SETUP: current cycle must be sel&enable with the captured addr/write/wdata. If not, error 1 -> IDLE. If ready -> complete. Otherwise -> ACCESS, wait counter=1.
  - ACCESS: sel, enable, addr, write or wdata differs from capture -> error 2 -> IDLE. ready -> complete. Otherwise wait counter+1; when it reaches TIMEOUT -> error 3 -> IDLE.
  - Complete: txn_count+1. Read: compare rdata with the registered shadow; mismatch -> error 4. Write: shadow updated at the next clock edge. Next state is SETUP if the following phase is sel&!enable (back-to-back), else IDLE.
- Shadow write rules:
  - TIME <= wdata.
  - ALARMi <= {wdata[DATA_W-1:1],1'b1} (bit0 = valid).
- Tick rules:
  - tick: TIME <= TIME+1, modulo 2^DATA_W.
  - Write to TIME completing in the same cycle as tick: write value loads, tick is dropped.
  - Read completing in a tick cycle compares against the pre-increment value.
- Error reporting, registered (visible one cycle after the detecting cycle):
  - fail <= 1.
  - err_count+1, saturating at all-ones.
  - err_code/err_addr <= code and captured addr (current addr for error 1).
  - first_code loads only when fail was 0.
  - At most one error per cycle. Priority: 3 > 2 > 1 > 4.
- fail_clr: fail, err_count, err_code, err_addr, first_code <= 0.
  - An error in the same cycle wins: fail=1, err_count=1, first_code=code.
  - Shadow and txn_count are unaffected.
- Reset asserted mid-transfer: all state clears immediately. No error is logged for the abandoned transfer.

Test Plan:
- Write TIME=0x0000_1234, then read TIME with rdata=0x0000_1234 -> fail=0, txn_count=2.
- Write ALARM2=0xABCD_0000, read ALARM2 returning 0xABCD_0001 -> no error; returning 0xABCD_0000 -> error 4, err_addr=0x0C, fail=1 one cycle later.
- Write TIME=5, 3 tick pulses, read returning 8 -> pass. Write TIME=0xFFFF_FFFF plus tick in the write's completion cycle, then read 0xFFFF_FFFF -> pass.
- sel&enable without setup (addr 0x00) -> error 1. Addr changed 0x00->0x04 mid-access -> error 2, err_count=2, first_code=1.
- Access with ready held low 16 cycles -> error 3 on cycle 16 and FSM IDLE. A following normal read passes.
- Error then fail_clr -> all error outputs 0. fail_clr in the same cycle as a mismatch -> fail=1, err_count=1. Unmapped read 0x40 returning 0 passes. Reset mid-access -> all outputs 0.
